multi_signal_timeout: RTL and testbench

Parametrised multi-channel activity watchdog. It monitors N_CH toggling status/heartbeat inputs (encoder strobes, ADC ready lines, comms heartbeats) and flags any channel that has not changed level for a programmable time. It adds per-channel enable, input synchronisation, sticky fault latching with clear, and first-fault capture for the protection logic of the vector-control core.

---
 rtl/multi_signal_timeout.sv | 155 +++++++++++++++
 tb/tb_multi_signal_timeout.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_signal_timeout.sv
// multi_signal_timeout: N_CH activity watchdog with sticky faults and first-fault capture.
// Optional stability filter after the synchronisers is enabled by defining GLITCH_FILTER_EN.
`default_nettype none

module multi_signal_timeout #(
  parameter int N_CH         = 4,
  parameter int CLK_FREQ_MHZ = 40,
  parameter int TIMEOUT_US   = 1000,
  parameter int CNT_W        = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_CYC     = 3,
  localparam int FF_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] SignalIn,
  input  logic [N_CH-1:0] Enable,
  input  logic            ClearFault,
  output logic [N_CH-1:0] TimeOut,
  output logic [N_CH-1:0] FaultLatched,
  output logic            AnyTimeOut,
  output logic [FF_W-1:0] FirstFaultCh,
  output logic            FirstFaultValid
);

  localparam longint PR_FULL = longint'(CLK_FREQ_MHZ) * longint'(TIMEOUT_US);
  localparam logic [CNT_W-1:0] PR    = CNT_W'(PR_FULL);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] PR_M1 = PR - ONE;

  generate
    if (PR_FULL == 0 || (PR_FULL >> CNT_W) != 0) begin : g_bad_pr
      $error("multi_signal_timeout: timeout period is zero or does not fit in CNT_W bits");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("multi_signal_timeout: SYNC_STAGES must be at least 2");
    end
    if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
      $error("multi_signal_timeout: N_CH must be within 1..32");
    end
    if (FILT_CYC < 1) begin : g_bad_filt
      $error("multi_signal_timeout: FILT_CYC must be at least 1");
    end
  endgenerate

  logic [N_CH-1:0] chg;
  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] fault;
  logic [FF_W-1:0] lowest_hit;
  logic [FF_W-1:0] ff_ch;
  logic            ff_valid;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   lvl_d;
    logic [CNT_W-1:0]       cnt;
    logic                   to_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], SignalIn[i]};
      end
    end

`ifdef GLITCH_FILTER_EN
    // A level change is accepted only once it has persisted FILT_CYC cycles.
    localparam int ST_W = $clog2(FILT_CYC + 1);
    logic [ST_W-1:0] stab;
    logic            filt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stab <= '0;
        filt <= 1'b0;
      end else if (sync_q[SYNC_STAGES-1] == filt) begin
        stab <= '0;
      end else if (stab == ST_W'(FILT_CYC - 1)) begin
        filt <= sync_q[SYNC_STAGES-1];
        stab <= '0;
      end else begin
        stab <= stab + 1'b1;
      end
    end

    assign lvl = filt;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lvl_d <= 1'b0;
      end else begin
        lvl_d <= lvl;
      end
    end

    assign chg[i] = lvl ^ lvl_d;

    // Saturating counter; TimeOut holds once PR is reached until activity or disable.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt  <= '0;
        to_q <= 1'b0;
      end else if (!Enable[i] || chg[i]) begin
        cnt  <= '0;
        to_q <= 1'b0;
      end else if (cnt != PR) begin
        cnt  <= cnt + ONE;
        to_q <= (cnt == PR_M1);
      end
    end

    assign hit[i]     = Enable[i] & ~chg[i] & (cnt == PR_M1);
    assign TimeOut[i] = to_q;
  end

  always_comb begin
    lowest_hit = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        lowest_hit = FF_W'(k);
      end
    end
  end

  // A new latch in the same cycle as ClearFault wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault    <= '0;
      ff_ch    <= '0;
      ff_valid <= 1'b0;
    end else begin
      fault <= (fault & {N_CH{~ClearFault}}) | hit;
      if ((|hit) && (!ff_valid || ClearFault)) begin
        ff_ch    <= lowest_hit;
        ff_valid <= 1'b1;
      end else if (ClearFault) begin
        ff_ch    <= '0;
        ff_valid <= 1'b0;
      end
    end
  end

  assign FaultLatched    = fault;
  assign FirstFaultCh    = ff_ch;
  assign FirstFaultValid = ff_valid;
  assign AnyTimeOut      = |TimeOut;

endmodule

`default_nettype wire

// File: tb/tb_multi_signal_timeout.sv
// Directed bench for multi_signal_timeout with PR = 1 MHz * 10 us = 10 cycles, four channels.
`default_nettype none

module tb_multi_signal_timeout;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] SignalIn;
  logic [N_CH-1:0] Enable;
  logic            ClearFault;
  logic [N_CH-1:0] TimeOut;
  logic [N_CH-1:0] FaultLatched;
  logic            AnyTimeOut;
  logic [1:0]      FirstFaultCh;
  logic            FirstFaultValid;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] to;
    logic [3:0] fl;
    logic [1:0] ch;
    logic       ch_care;
    logic       v;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  multi_signal_timeout #(
    .N_CH(N_CH), .CLK_FREQ_MHZ(1), .TIMEOUT_US(10), .CNT_W(8),
    .SYNC_STAGES(2), .FILT_CYC(3)
  ) dut (
    .clk(clk), .rst(rst), .SignalIn(SignalIn), .Enable(Enable),
    .ClearFault(ClearFault), .TimeOut(TimeOut), .FaultLatched(FaultLatched),
    .AnyTimeOut(AnyTimeOut), .FirstFaultCh(FirstFaultCh),
    .FirstFaultValid(FirstFaultValid)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [3:0] to, input logic [3:0] fl,
                          input logic [1:0] ch, input logic ch_care, input logic v);
    exp_t e;
    e.to = to; e.fl = fl; e.ch = ch; e.ch_care = ch_care; e.v = v;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_next();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty got=0 exp=1 entries");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (TimeOut === e.to) else begin
      failures++; $error("FAIL %s TimeOut got=%b exp=%b", t, TimeOut, e.to);
    end
    checks++;
    assert (FaultLatched === e.fl) else begin
      failures++; $error("FAIL %s FaultLatched got=%b exp=%b", t, FaultLatched, e.fl);
    end
    checks++;
    assert (AnyTimeOut === (|e.to)) else begin
      failures++; $error("FAIL %s AnyTimeOut got=%b exp=%b", t, AnyTimeOut, |e.to);
    end
    checks++;
    assert (FirstFaultValid === e.v) else begin
      failures++; $error("FAIL %s FirstFaultValid got=%b exp=%b", t, FirstFaultValid, e.v);
    end
    if (e.ch_care) begin
      checks++;
      assert (FirstFaultCh === e.ch) else begin
        failures++; $error("FAIL %s FirstFaultCh got=%0d exp=%0d", t, FirstFaultCh, e.ch);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    SignalIn   = '0;
    Enable     = '1;
    ClearFault = 1'b0;
    tick(2);
    push_exp("reset", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0); check_next();

    // All channels static: timeout exactly 10 cycles after release.
    rst = 1'b0;
    tick(9);
    push_exp("static_pre", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0); check_next();
    tick(1);
    push_exp("static_to", 4'b1111, 4'b1111, 2'd0, 1'b1, 1'b1); check_next();

    // Channel 1 toggled every 8 cycles never times out; last toggle + 13 it does.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      SignalIn[1] = ~SignalIn[1];
      tick(8);
      if (k == 0) push_exp("toggle_early", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      else        push_exp("toggle_ch1", 4'b1101, 4'b1101, 2'd0, 1'b1, 1'b1);
      check_next();
    end
    tick(4);
    push_exp("toggle_stop_pre", 4'b1101, 4'b1101, 2'd0, 1'b1, 1'b1); check_next();
    tick(1);
    push_exp("toggle_stop_to", 4'b1111, 4'b1111, 2'd0, 1'b1, 1'b1); check_next();

    // Only channel 2 enabled; clear while still timed out; then activity.
    Enable   = 4'b0100;
    SignalIn = '0;
    do_reset();
    tick(9);
    push_exp("ch2_pre", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0); check_next();
    tick(1);
    push_exp("ch2_to", 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1); check_next();
    ClearFault = 1'b1;
    tick(1);
    ClearFault = 1'b0;
    push_exp("ch2_clear", 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0); check_next();
    tick(3);
    push_exp("ch2_no_relatch", 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0); check_next();
    SignalIn[2] = 1'b1;
    tick(2);
    push_exp("ch2_edge_pre", 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0); check_next();
    tick(1);
    push_exp("ch2_edge", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0); check_next();

    // ch0 faults first; ch1 and ch3 later together while ClearFault is asserted.
    Enable   = 4'b1011;
    SignalIn = '0;
    do_reset();
    SignalIn[1] = 1'b1;
    SignalIn[3] = 1'b1;
    tick(10);
    push_exp("ch0_first", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1); check_next();
    tick(2);
    push_exp("ch13_pre", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1); check_next();
    ClearFault = 1'b1;
    tick(1);
    ClearFault = 1'b0;
    push_exp("set_beats_clear", 4'b1011, 4'b1010, 2'd1, 1'b1, 1'b1); check_next();

    // Asynchronous reset clears outputs before the next clock edge.
    rst      = 1'b1;
    SignalIn = '0;
    Enable   = '1;
    #2;
    push_exp("async_rst", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0); check_next();
    tick(1);
    rst = 1'b0;
    tick(7);
    push_exp("mid_count", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0); check_next();
    rst = 1'b1;
    #2;
    push_exp("mid_rst", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0); check_next();
    tick(1);
    rst = 1'b0;
    tick(9);
    push_exp("after_rst_pre", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0); check_next();
    tick(1);
    push_exp("after_rst_to", 4'b1111, 4'b1111, 2'd0, 1'b1, 1'b1); check_next();

`ifdef GLITCH_FILTER_EN
    // Two-cycle pulse is ignored; three-cycle pulse resets channel 0.
    Enable   = 4'b0001;
    SignalIn = '0;
    do_reset();
    tick(8);
    SignalIn[0] = 1'b1;
    tick(2);
    SignalIn[0] = 1'b0;
    push_exp("glitch2_to", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1); check_next();
    tick(4);
    push_exp("glitch2_hold", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1); check_next();
    SignalIn[0] = 1'b1;
    tick(3);
    SignalIn[0] = 1'b0;
    tick(2);
    push_exp("glitch3_pre", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1); check_next();
    tick(1);
    push_exp("glitch3_edge", 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1); check_next();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
